// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate sweep checkers: reference op codes and FSM states.
package gate_chk_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Purely combinational reference gate: reduces the input vector per OP.
// Unknown OP codes fall back to AND so a typo still yields a defined checker.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int OP   = OP_AND
) (
    input  logic [N_IN-1:0] vec_i,
    output logic            exp_o
);

    always_comb begin
        exp_o = &vec_i;
        case (OP)
            OP_AND:  exp_o = &vec_i;
            OP_OR:   exp_o = |vec_i;
            OP_XOR:  exp_o = ^vec_i;
            OP_NAND: exp_o = ~&vec_i;
            OP_NOR:  exp_o = ~|vec_i;
            OP_XNOR: exp_o = ~^vec_i;
            default: exp_o = &vec_i;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine: walks every input vector into a gate DUT, holds it
// for SETTLE cycles, then compares dut_y against the reference and tallies errors.
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int OP     = OP_AND,
    parameter int SETTLE = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int            CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    chk_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN:0]   err_q;
    logic [N_IN:0]   err_d;
    logic            ffv_q;
    logic [N_IN-1:0] ffvec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            expY;
    logic            mismatch;

    gate_ref_model #(
        .N_IN (N_IN),
        .OP   (OP)
    ) u_ref (
        .vec_i (vec_q),
        .exp_o (expY)
    );

    // err_count is one bit wider than the vector so the all-fail total cannot wrap.
    assign mismatch = (dut_y != expY);
    assign err_d    = mismatch ? err_q + (N_IN+1)'(1) : err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_APPLY;
                        cnt_q   <= '0;
                        vec_q   <= '0;
                        err_q   <= '0;
                        ffv_q   <= 1'b0;
                        ffvec_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !ffv_q) begin
                        ffv_q   <= 1'b1;
                        ffvec_q <= vec_q;
                    end
                    // pass is derived from the count including this final compare.
                    if (vec_q == '1) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        state_q <= ST_APPLY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(busy_q && done_q));
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two checker instances (2-input AND, 3-input XNOR)
// driving truth-table gates, compared every cycle against a sweep-progress model.
module tb_gate_sweep_checker;
    import gate_chk_pkg::*;

    localparam int S = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic       start2 = 1'b0;
    logic       start3 = 1'b0;
    logic [3:0] gateTbl2 = 4'b1000;
    logic [7:0] gateTbl3 = 8'b10010110;

    logic [1:0] vec2;
    logic       busy2, done2, pass2, ffv2, y2;
    logic [2:0] err2;
    logic [1:0] ffvec2;
    logic [2:0] vec3;
    logic       busy3, done3, pass3, ffv3, y3;
    logic [3:0] err3;
    logic [2:0] ffvec3;

    assign y2 = gateTbl2[vec2];
    assign y3 = gateTbl3[vec3];

    gate_sweep_checker #(.N_IN(2), .OP(OP_AND), .SETTLE(S)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .vec_out(vec2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    gate_sweep_checker #(.N_IN(3), .OP(OP_XNOR), .SETTLE(S)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
    );

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference gate computed from the count of ones in the vector.
    function automatic bit refBit(input int n, input int op, input int v);
        int ones;
        bit r;
        ones = $countones(v);
        case (op)
            OP_OR:   r = (ones > 0);
            OP_XOR:  r = (ones % 2) == 1;
            OP_NAND: r = (ones != n);
            OP_NOR:  r = (ones == 0);
            OP_XNOR: r = (ones % 2) == 0;
            default: r = (ones == n);
        endcase
        return r;
    endfunction

    typedef struct {
        int vec;
        int busy;
        int done;
        int pass;
        int err;
        int ffv;
        int ffvec;
    } expT;

    // Expected outputs k clock edges after a start, from sweep arithmetic alone.
    function automatic expT modelExpect(input int n, input int op, input bit run,
                                        input int k, input logic [7:0] tbl);
        expT e;
        int  tot;
        int  c;
        e   = '{default: 0};
        tot = (1 << n) * (S + 1);
        if (!run) return e;
        c = k / (S + 1);
        if (c > (1 << n)) c = 1 << n;
        e.busy = (k < tot) ? 1 : 0;
        e.done = (k >= tot) ? 1 : 0;
        e.vec  = (e.done == 1) ? (1 << n) - 1 : c;
        for (int v = 0; v < c; v++) begin
            if (tbl[v] != refBit(n, op, v)) begin
                if (e.err == 0) e.ffvec = v;
                e.err++;
            end
        end
        e.ffv  = (e.err > 0) ? 1 : 0;
        e.pass = (e.done == 1 && e.err == 0) ? 1 : 0;
        return e;
    endfunction

    bit         run2 = 1'b0;
    bit         run3 = 1'b0;
    int         k2 = 0;
    int         k3 = 0;
    logic [7:0] mTbl2 = '0;
    logic [7:0] mTbl3 = '0;

    always @(posedge clk) begin
        if (rst) begin
            run2 = 1'b0; k2 = 0;
            run3 = 1'b0; k3 = 0;
        end else begin
            if (start2 && (!run2 || k2 >= 4 * (S + 1))) begin
                run2 = 1'b1; k2 = 0; mTbl2 = {4'b0000, gateTbl2};
            end else if (run2 && k2 < 4 * (S + 1)) begin
                k2++;
            end
            if (start3 && (!run3 || k3 >= 8 * (S + 1))) begin
                run3 = 1'b1; k3 = 0; mTbl3 = gateTbl3;
            end else if (run3 && k3 < 8 * (S + 1)) begin
                k3++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        expT e;
        if (checkEn) begin
            e = modelExpect(2, OP_AND, run2, k2, mTbl2);
            checkOutput("d2.vec_out", int'(vec2), e.vec);
            checkOutput("d2.busy", int'(busy2), e.busy);
            checkOutput("d2.done", int'(done2), e.done);
            checkOutput("d2.pass", int'(pass2), e.pass);
            checkOutput("d2.err_count", int'(err2), e.err);
            checkOutput("d2.ff_valid", int'(ffv2), e.ffv);
            checkOutput("d2.ff_vec", int'(ffvec2), e.ffvec);
            e = modelExpect(3, OP_XNOR, run3, k3, mTbl3);
            checkOutput("d3.vec_out", int'(vec3), e.vec);
            checkOutput("d3.busy", int'(busy3), e.busy);
            checkOutput("d3.done", int'(done3), e.done);
            checkOutput("d3.pass", int'(pass3), e.pass);
            checkOutput("d3.err_count", int'(err3), e.err);
            checkOutput("d3.ff_valid", int'(ffv3), e.ffv);
            checkOutput("d3.ff_vec", int'(ffvec3), e.ffvec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit to2, input bit to3);
        start2 = to2;
        start3 = to3;
        tick();
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic waitDone2(output int n);
        n = 0;
        while (!done2 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic waitDone3(output int n);
        n = 0;
        while (!done3 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin : stim
        int n;
        bit aborted;
        rst = 1'b1;
        repeat (2) tick();
        checkEn = 1'b1;
        checkOutput("rst.vec2", int'(vec2), 0);
        checkOutput("rst.busy2", int'(busy2), 0);
        checkOutput("rst.done2", int'(done2), 0);
        checkOutput("rst.err3", int'(err3), 0);
        rst = 1'b0;
        tick();

        // T1: correct AND gate
        gateTbl2 = 4'b1000;
        applyStimulus(1'b1, 1'b0);
        checkOutput("T1.vec_first", int'(vec2), 0);
        waitDone2(n);
        checkOutput("T1.latency", n, 24);
        checkOutput("T1.pass", int'(pass2), 1);
        checkOutput("T1.err", int'(err2), 0);
        checkOutput("T1.ffv", int'(ffv2), 0);

        // T2: OR gate in place of AND
        gateTbl2 = 4'b1110;
        applyStimulus(1'b1, 1'b0);
        waitDone2(n);
        checkOutput("T2.latency", n, 24);
        checkOutput("T2.err", int'(err2), 2);
        checkOutput("T2.pass", int'(pass2), 0);
        checkOutput("T2.ffv", int'(ffv2), 1);
        checkOutput("T2.ffvec", int'(ffvec2), 1);

        // T3: stuck-at-0 gate
        gateTbl2 = 4'b0000;
        applyStimulus(1'b1, 1'b0);
        waitDone2(n);
        checkOutput("T3.err", int'(err2), 1);
        checkOutput("T3.ffvec", int'(ffvec2), 3);

        // T4: start ignored mid-sweep, reset aborts, fresh sweep passes
        gateTbl2 = 4'b1000;
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (vec2 != 2'd1 && n < 100) begin tick(); n++; end
        checkOutput("T4.reachVec1", int'(vec2), 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("T4.ignoredVec", int'(vec2), 1);
        checkOutput("T4.ignoredBusy", int'(busy2), 1);
        n = 0;
        while (vec2 != 2'd2 && n < 100) begin tick(); n++; end
        checkOutput("T4.reachVec2", int'(vec2), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("T4.rstVec", int'(vec2), 0);
        checkOutput("T4.rstBusy", int'(busy2), 0);
        checkOutput("T4.rstDone", int'(done2), 0);
        tick();
        checkOutput("T4.idleBusy", int'(busy2), 0);
        applyStimulus(1'b1, 1'b0);
        waitDone2(n);
        checkOutput("T4.latency", n, 24);
        checkOutput("T4.pass", int'(pass2), 1);

        // T6: restart from DONE-with-errors using a correct gate
        gateTbl2 = 4'b1110;
        applyStimulus(1'b1, 1'b0);
        waitDone2(n);
        checkOutput("T6.errFirst", int'(err2), 2);
        gateTbl2 = 4'b1000;
        applyStimulus(1'b1, 1'b0);
        checkOutput("T6.doneDrop", int'(done2), 0);
        checkOutput("T6.errClear", int'(err2), 0);
        checkOutput("T6.ffvClear", int'(ffv2), 0);
        waitDone2(n);
        checkOutput("T6.pass", int'(pass2), 1);

        // T5: 3-input XNOR reference against an XOR gate
        gateTbl3 = 8'b10010110;
        applyStimulus(1'b0, 1'b1);
        waitDone3(n);
        checkOutput("T5.latency", n, 48);
        checkOutput("T5.err", int'(err3), 8);
        checkOutput("T5.ffv", int'(ffv3), 1);
        checkOutput("T5.ffvec", int'(ffvec3), 0);
        checkOutput("T5.pass", int'(pass3), 0);

        // Random truth tables, spurious starts while busy, occasional reset
        for (int it = 0; it < 12; it++) begin
            gateTbl2 = 4'($urandom);
            gateTbl3 = 8'($urandom);
            applyStimulus(1'b1, 1'b1);
            aborted = 1'b0;
            for (int c = 0; c < 400 && !(done2 && done3) && !aborted; c++) begin
                start2 = busy2 && ($urandom_range(0, 7) == 0);
                start3 = busy3 && ($urandom_range(0, 7) == 0);
                if (it % 4 == 3 && $urandom_range(0, 39) == 0) begin
                    rst = 1'b1;
                    aborted = 1'b1;
                end
                tick();
                rst    = 1'b0;
                start2 = 1'b0;
                start3 = 1'b0;
            end
            if (!aborted) begin
                checkOutput("rnd.done2", int'(done2), 1);
                checkOutput("rnd.done3", int'(done3), 1);
            end
            tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
